// File: rtl/noc_switch_allocator.sv
// Purpose: round-robin switch allocator; each output is held by one input for a whole wormhole packet.
// Latency: a head flit requested in cycle n pops no earlier than n+1; one idle cycle per packet on each output.
// Backpressure: out_ready_i low keeps the lock and blocks pop_o; out_valid_o still follows the owner's request.
// Ports: req_i/route_i/tail_i describe each input FIFO head; out_ready_i is downstream readiness per output;
//        out_valid_o/sel_o drive the crossbar; pop_o pops the input FIFOs; err_o latches illegal route codes.
module noc_switch_allocator #(
  parameter int NPORTS = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NPORTS-1:0]     req_i,
  input  logic [3*NPORTS-1:0]   route_i,
  input  logic [NPORTS-1:0]     tail_i,
  input  logic [NPORTS-1:0]     out_ready_i,
  output logic [NPORTS-1:0]     out_valid_o,
  output logic [3*NPORTS-1:0]   sel_o,
  output logic [NPORTS-1:0]     pop_o,
  output logic                  err_o
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [2:0] NO_OWNER = 3'b111;

  state_t            state_q [NPORTS];
  state_t            state_d [NPORTS];
  logic [2:0]        ptr_q   [NPORTS];
  logic [2:0]        ptr_d   [NPORTS];
  logic [2:0]        owner_q [NPORTS];
  logic [2:0]        owner_d [NPORTS];
  logic              err_q;
  logic [NPORTS-1:0] is_owner;
  logic [NPORTS-1:0] illegal;
  logic [NPORTS-1:0] cand    [NPORTS];

  // An input that already owns an output is mid-packet: its head flit is a
  // body flit with no header, so its route field must not be interpreted.
  always_comb begin
    is_owner = '0;
    for (int o = 0; o < NPORTS; o++) begin
      if (state_q[o] == LOCKED) begin
        for (int p = 0; p < NPORTS; p++) begin
          if (owner_q[o] == 3'(p)) is_owner[p] = 1'b1;
        end
      end
    end
  end

  // Candidate matrix cand[o][p]; an illegal code matches no output, so such
  // an input is never granted and never popped.
  always_comb begin
    illegal = '0;
    for (int o = 0; o < NPORTS; o++) cand[o] = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (req_i[p] && !is_owner[p]) begin
        if (route_i[3*p +: 3] > 3'(NPORTS - 1)) illegal[p] = 1'b1;
        for (int o = 0; o < NPORTS; o++) begin
          if (route_i[3*p +: 3] == 3'(o)) cand[o][p] = 1'b1;
        end
      end
    end
  end

  // Per-output FSM next state plus the combinational transfer strobes.
  always_comb begin
    logic       found;
    logic [2:0] cidx;
    found       = 1'b0;
    cidx        = '0;
    out_valid_o = '0;
    pop_o       = '0;
    for (int o = 0; o < NPORTS; o++) begin
      state_d[o] = state_q[o];
      ptr_d[o]   = ptr_q[o];
      owner_d[o] = owner_q[o];
      found      = 1'b0;
      case (state_q[o])
        IDLE: begin
          // First candidate at or after the pointer, wrapping modulo NPORTS.
          for (int k = 0; k < NPORTS; k++) begin
            cidx = 3'((int'(ptr_q[o]) + k) % NPORTS);
            if (!found && cand[o][cidx]) begin
              found      = 1'b1;
              state_d[o] = LOCKED;
              owner_d[o] = cidx;
              ptr_d[o]   = 3'((int'(cidx) + 1) % NPORTS);
            end
          end
        end
        LOCKED: begin
          for (int p = 0; p < NPORTS; p++) begin
            if (owner_q[o] == 3'(p)) begin
              out_valid_o[o] = req_i[p];
              if (req_i[p] && out_ready_i[o]) begin
                pop_o[p] = 1'b1;
                if (tail_i[p]) begin
                  state_d[o] = IDLE;
                  owner_d[o] = NO_OWNER;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int o = 0; o < NPORTS; o++) begin
        state_q[o] <= IDLE;
        ptr_q[o]   <= '0;
        owner_q[o] <= NO_OWNER;
      end
      err_q <= 1'b0;
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        state_q[o] <= state_d[o];
        ptr_q[o]   <= ptr_d[o];
        owner_q[o] <= owner_d[o];
      end
      err_q <= err_q | (|illegal);
    end
  end

  always_comb begin
    for (int o = 0; o < NPORTS; o++) sel_o[3*o +: 3] = owner_q[o];
  end

  assign err_o = err_q;

endmodule

// File: doc/noc_switch_allocator.md
# noc_switch_allocator

Per-router switch allocator for the mesh NoC. It takes the 3-bit output direction computed for each input port's head flit by the YX route stage and grants each of the five router outputs to one input at a time, using round-robin arbitration. A grant is held for the whole wormhole packet until its tail flit transfers. The block drives the crossbar selects and the input-FIFO pop strobes.

## Interface
Parameters:
- NPORTS, 5, number of router ports; fixed encoding 0=north, 1=south, 2=west, 3=east, 4=local (matches route-stage direction codes 000..100)

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- req_i  input  5  bit p: input FIFO p has a valid flit at its head
- route_i  input  15  bits [3p+2:3p]: direction code of input p's head flit (meaningful only when input p is not owning an output)
- tail_i  input  5  bit p: head flit of input p is the last flit of its packet (head and tail may be the same flit)
- out_ready_i  input  5  bit o: downstream of output o can accept a flit this cycle
- out_valid_o  output  5  bit o: crossbar output o carries a valid flit this cycle
- sel_o  output  15  bits [3o+2:3o]: input index driving output o; 3'b111 when output o is idle
- pop_o  output  5  bit p: flit at head of input p transfers this cycle
- err_o  output  1  sticky: a requesting input presented an illegal route code (101..111)

## Operation
- Each output o has a 1-bit FSM, a 3-bit round-robin pointer ptr[o] (range 0..4) and a 3-bit owner register owner[o].
- The FSM states are:
  - IDLE: the candidates for o are the inputs p with req_i[p]=1, route_i[p]==o, and p not currently owner of any output. If any candidate exists, the winner is the first candidate searching ptr[o], ptr[o]+1, ... modulo 5. At the next edge: owner[o]<=winner, state<=LOCKED, ptr[o]<=(winner+1) mod 5. With no candidate, state and ptr are unchanged.
  - LOCKED: out_valid_o[o]=req_i[owner[o]]; pop_o[owner[o]]=req_i[owner[o]] & out_ready_i[o]. If that pop occurs with tail_i[owner[o]]=1, then at the next edge state<=IDLE and owner[o]<=3'b111. route_i of the owner is ignored while LOCKED, because body flits carry no header.
- sel_o[o]=owner[o] (registered). The pop_o and out_valid_o outputs are combinational from registered state plus req_i/out_ready_i/tail_i.
- An input is owner of at most one output by construction. Two outputs never select the same input.
- Illegal route codes (101, 110, 111) with req_i[p]=1 and p not an owner:
  - p is never a candidate, so it is never popped.
  - err_o is set at the next edge and stays set until reset.
- All five outputs arbitrate independently in the same cycle. Distinct outputs can grant distinct inputs simultaneously.

## Timing
- Reset (asynchronous assert, synchronous release to the first edge): all FSMs IDLE, ptr=0, owner=3'b111, sel_o=15'h7FFF, out_valid_o=0, pop_o=0, err_o=0.
- Arbitration latency is 1 cycle. If a head flit is requested in cycle n, its earliest pop is in cycle n+1.
- Tail pop in cycle n frees the output at edge n/n+1. The output re-arbitrates in cycle n+1, so the next packet's earliest pop is cycle n+2 (one bubble per packet).
- A single-flit packet locks at edge n and pops and unlocks in cycle n+1 if out_ready_i is high.
- Backpressure: while out_ready_i[o]=0, the lock is held, pop_o is 0 and out_valid_o may stay 1. There is no timeout.
- req_i[owner] low while LOCKED is a FIFO bubble: no pop, lock held.
- An input released at a tail pop in cycle n may be a candidate for any output in cycle n+1.
- Reset asserted mid-packet drops all locks immediately. Outputs return to reset values without waiting for a clock edge.

## Test plan
- Single-flit local delivery: input 2 sends req, route=100, tail=1, out_ready=all 1. Required: sel_o[14:12]=2 after 1 edge; pop_o=5'b00100 for exactly one cycle; output 4 then returns to idle (sel 111).
- Round-robin: inputs 0, 1 and 3 all request route=011 (east) with single-flit packets continuously. Required grant order on output 3 is 0, 1, 3, 0, 1, 3, with each pop two cycles apart.
- Wormhole lock: input 1 sends a 4-flit packet to north while input 4 also requests north. Required: 4 consecutive pops of input 1 with input 4 held off; input 4 is granted in the cycle after the tail pop.
- Backpressure: lock north, hold out_ready_i[0]=0 for 3 cycles mid-packet. Required: pop_o=0, out_valid_o[0]=1 and sel unchanged during those cycles; transfer resumes when ready returns.
- Parallel outputs plus illegal route:
  - input 0 requests route=010, input 2 requests route=001 and input 3 requests route=110, all in the same cycle.
  - Required: outputs 2 and 1 are granted in the same edge; input 3 is never popped; err_o=1 from the next edge until rst_i.
- Reset mid-packet: assert rst_i asynchronously during a locked 3-flit transfer. Required: sel_o=7FFF, pop_o=0 and out_valid_o=0 immediately; ptr=0 after release.
